// File: rtl/cache_pkg.sv
// Constants and state encoding for the cache miss-fill path. The cache and the
// memory arbiter import the same definitions.
package cache_pkg;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = BLOCK_BYTES / 2;
  localparam int MEM_LATENCY     = 4;
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK) + 1;

  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    IDLE  = 2'd1,
    FILL  = 2'd2
  } fill_state_t;

  // Byte address of word idx inside the block at base. The sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    logic [ADDR_W-1:0] off;
    off = '0;
    off[CNT_W:1] = idx;
    return base + off;
  endfunction
endpackage

// File: rtl/fill_counter.sv
// Loadable counter with enable and a terminal-count flag. It counts up by default,
// and counts down when DOWN is set.
module fill_counter #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] TC_VAL  = '0,
  parameter bit           DOWN    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         tc
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= RST_VAL;
    else if (load) q <= load_val;
    else if (en)   q <= DOWN ? q - 1'b1 : q + 1'b1;
  end

  assign tc = (q == TC_VAL);
endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller. It fetches one 16-byte block as 8 word reads, streams the
// returned words into the data array, and commits the tag with the last word.
//   state | meaning
//   DRAIN | after reset, swallow responses to requests issued before the reset
//   IDLE  | wait for a miss
//   FILL  | issue reads and write back returned words
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_grant,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data_in,
  output logic              fsm_busy,
  output logic              memory_read_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data
);
  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt, drain_cnt;
  logic              issue_done, recv_last, drain_last;
  logic              in_fill, start, issue_en, accept;

  assign in_fill  = (state == FILL);
  assign start    = (state == IDLE) && miss_detected;
  assign issue_en = in_fill && !issue_done && mem_grant;
  // A word is accepted only if it answers a request. Anything else is dropped.
  assign accept   = in_fill && memory_data_valid && (recv_cnt < issue_cnt);

  fill_counter #(.W(CNT_W), .RST_VAL('0), .TC_VAL(CNT_W'(WORDS_PER_BLOCK)), .DOWN(1'b0))
    u_issue (.clk(clk), .rst(rst), .load(start), .load_val('0), .en(issue_en),
             .q(issue_cnt), .tc(issue_done));

  fill_counter #(.W(CNT_W), .RST_VAL('0), .TC_VAL(CNT_W'(WORDS_PER_BLOCK - 1)), .DOWN(1'b0))
    u_recv (.clk(clk), .rst(rst), .load(start), .load_val('0), .en(accept),
            .q(recv_cnt), .tc(recv_last));

  fill_counter #(.W(CNT_W), .RST_VAL(CNT_W'(MEM_LATENCY)), .TC_VAL(CNT_W'(1)), .DOWN(1'b1))
    u_drain (.clk(clk), .rst(rst), .load(1'b0), .load_val('0), .en(state == DRAIN),
             .q(drain_cnt), .tc(drain_last));

  always_comb begin
    state_nxt = state;
    case (state)
      DRAIN:   if (drain_last) state_nxt = IDLE;
      IDLE:    if (miss_detected) state_nxt = FILL;
      FILL:    if (accept && recv_last) state_nxt = IDLE;
      default: state_nxt = DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DRAIN;
      base  <= '0;
    end else begin
      state <= state_nxt;
      if (start) base <= {miss_address[ADDR_W-1:4], 4'h0};
    end
  end

  // Outputs are combinational, so they are forced to zero while reset is held.
  always_comb begin
    fsm_busy         = 1'b0;
    memory_read_req  = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_addr        = '0;
    fill_data        = '0;
    if (rst) begin
      fsm_busy         = in_fill;
      memory_read_req  = in_fill && !issue_done;
      memory_address   = in_fill ? word_addr(base, issue_cnt) : '0;
      write_data_array = accept;
      write_tag_array  = accept && recv_last;
      fill_addr        = in_fill ? word_addr(base, recv_cnt) : miss_address;
      fill_data        = memory_data_in;
    end
  end

  a_no_unrequested_word: assert property (@(posedge clk) disable iff (!rst)
    !(in_fill && memory_data_valid && (recv_cnt >= issue_cnt)));

  a_drain_nonzero: assert property (@(posedge clk) disable iff (!rst)
    (state == DRAIN) |-> (drain_cnt != '0));
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm. It compares the design against a queue-based model of the
// fill (pending request and write addresses) and a fixed-latency in-order memory.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic        clk = 1'b0, rst = 1'b0;
  logic        miss_detected = 1'b0, mem_grant = 1'b0, memory_data_valid = 1'b0;
  logic [15:0] miss_address = '0, memory_data_in = '0;
  logic        fsm_busy, memory_read_req, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_addr, fill_data;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_grant(mem_grant), .memory_data_valid(memory_data_valid),
    .memory_data_in(memory_data_in), .fsm_busy(fsm_busy), .memory_read_req(memory_read_req),
    .memory_address(memory_address), .write_data_array(write_data_array),
    .write_tag_array(write_tag_array), .fill_addr(fill_addr), .fill_data(fill_data));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;

  typedef struct {int due; logic [15:0] addr;} mreq_t;
  mreq_t       mq[$];
  logic [15:0] rq[$], wq[$];
  int          drain_left = MEM_LATENCY;

  logic        log_req[8192], log_wr[8192], log_tag[8192], log_busy[8192];
  logic [15:0] log_maddr[8192], log_faddr[8192];

  typedef struct {
    logic miss, grant, busy, req, wr, tag;
    logic [15:0] maddr, faddr;
  } vec_t;
  vec_t t2[14];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle. It drives the inputs, checks the outputs mid-cycle against the model,
  // and then advances the model.
  task automatic cycle(input logic miss, input logic [15:0] a, input logic g, input logic stray);
    logic filling, exp_req, exp_wr, exp_tag;
    logic [15:0] b;
    mreq_t r;
    miss_detected = miss; miss_address = a; mem_grant = g;
    memory_data_valid = 1'b0; memory_data_in = 16'($urandom);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data_in = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else if (stray && wq.size() == 0) begin
      memory_data_valid = 1'b1;
    end
    #3;
    log_req[cyc] = memory_read_req; log_wr[cyc] = write_data_array;
    log_tag[cyc] = write_tag_array; log_busy[cyc] = fsm_busy;
    log_maddr[cyc] = memory_address; log_faddr[cyc] = fill_addr;
    if (!rst) begin
      chk("rst_ctrl", {fsm_busy, memory_read_req, write_data_array, write_tag_array}, 0);
      chk("rst_mem_addr", memory_address, 0);
      chk("rst_fill_addr", fill_addr, 0);
      chk("rst_fill_data", fill_data, 0);
      rq.delete(); wq.delete(); drain_left = MEM_LATENCY;
    end else begin
      filling = wq.size() > 0;
      exp_req = filling && rq.size() > 0;
      exp_wr  = filling && memory_data_valid;
      exp_tag = exp_wr && wq.size() == 1;
      chk("busy", fsm_busy, filling);
      chk("req", memory_read_req, exp_req);
      if (exp_req) chk("mem_addr", memory_address, rq[0]);
      chk("wr_data", write_data_array, exp_wr);
      chk("wr_tag", write_tag_array, exp_tag);
      if (exp_wr) begin
        chk("fill_addr", fill_addr, wq[0]);
        chk("fill_data", fill_data, mem_word(wq[0]));
      end else if (!filling) begin
        chk("fill_addr_idle", fill_addr, a);
      end
      if (filling) begin
        if (exp_req && g) begin
          r.due = cyc + MEM_LATENCY; r.addr = rq[0];
          mq.push_back(r);
          void'(rq.pop_front());
        end
        if (exp_wr) void'(wq.pop_front());
      end else if (drain_left > 0) begin
        drain_left--;
      end else if (miss) begin
        b = {a[15:4], 4'h0};
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
          rq.push_back(b + 16'(2 * i));
          wq.push_back(b + 16'(2 * i));
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((wq.size() > 0 || drain_left > 0) && n < 60) begin
      cycle(1'b0, 16'($urandom), 1'b1, 1'b0);
      n++;
    end
    chk("wait_idle_timeout", n >= 60, 0);
  endtask

  initial begin
    int t0, nw, nt, n, c1234;
    logic any;
    for (int c = 0; c < 14; c++) begin
      t2[c].miss  = (c == 0);
      t2[c].grant = 1'b1;
      t2[c].busy  = (c >= 1 && c <= 12);
      t2[c].req   = (c >= 1 && c <= 8);
      t2[c].maddr = 16'h1230 + 16'(2 * (c - 1));
      t2[c].wr    = (c >= 5 && c <= 12);
      t2[c].faddr = t2[c].wr ? 16'h1230 + 16'(2 * (c - 5)) : 16'h1234;
      t2[c].tag   = (c == 12);
    end

    @(posedge clk); #1;
    // Test 1: outputs held at zero in reset, then four drain cycles before the miss is taken.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h1234, 1'b1, 1'b1);
    rst = 1'b1; t0 = cyc;
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    any = 1'b0;
    for (int i = 0; i < 4; i++) any = any | log_busy[t0 + i] | log_req[t0 + i];
    chk("t1_drain_quiet", any, 0);
    chk("t1_no_req_c4", log_req[t0 + 4], 0);
    chk("t1_req_c5", log_req[t0 + 5], 1);
    wait_idle();

    // Test 2: table-driven fill with grant held high.
    for (int c = 0; c < 14; c++) begin
      cycle(t2[c].miss, 16'h1234, t2[c].grant, 1'b0);
      chk("t2_busy", log_busy[cyc - 1], t2[c].busy);
      chk("t2_req", log_req[cyc - 1], t2[c].req);
      if (t2[c].req) chk("t2_mem_addr", log_maddr[cyc - 1], t2[c].maddr);
      chk("t2_wr", log_wr[cyc - 1], t2[c].wr);
      if (t2[c].wr || !t2[c].busy) chk("t2_fill_addr", log_faddr[cyc - 1], t2[c].faddr);
      chk("t2_tag", log_tag[cyc - 1], t2[c].tag);
    end

    // Test 3: grant withheld on cycles 3-5.
    t0 = cyc;
    for (int c = 0; c < 17; c++) cycle(c == 0, 16'h1234, !(c >= 3 && c <= 5), 1'b0);
    c1234 = 0; nw = 0; nt = 0;
    for (int c = 0; c < 17; c++) begin
      if (log_req[t0 + c] && log_maddr[t0 + c] == 16'h1234) c1234++;
      if (log_wr[t0 + c]) nw++;
      if (log_tag[t0 + c]) nt++;
    end
    chk("t3_held_addr_cycles", c1234, 4);
    chk("t3_write_count", nw, 8);
    chk("t3_tag_count", nt, 1);
    chk("t3_tag_c15", log_tag[t0 + 15], 1);
    chk("t3_idle_c16", log_busy[t0 + 16], 0);

    // Test 4: reset after three words, stray responses drained, then a clean fill.
    cycle(1'b1, 16'h0080, 1'b1, 1'b0);
    nw = 0; n = 0;
    while (nw < 3 && n < 20) begin
      cycle(1'b0, 16'h0080, 1'b1, 1'b0);
      if (log_wr[cyc - 1]) nw++;
      n++;
    end
    chk("t4_three_words", nw, 3);
    rst = 1'b0;
    cycle(1'b1, 16'h0080, 1'b1, 1'b1);
    rst = 1'b1; t0 = cyc;
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0040, 1'b1, 1'b1);
    any = 1'b0;
    for (int i = 0; i < 4; i++) any = any | log_wr[t0 + i];
    chk("t4_no_stray_write", any, 0);
    t0 = cyc;
    cycle(1'b1, 16'h0040, 1'b1, 1'b0);
    wait_idle();
    nw = 0;
    for (int c = t0; c < cyc; c++) if (log_wr[c]) nw++;
    chk("t4_refill_writes", nw, 8);

    // Test 5: responses while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0200, 1'b1, 1'b1);
      chk("t5_idle_wr", log_wr[cyc - 1], 0);
      chk("t5_idle_busy", log_busy[cyc - 1], 0);
    end
    cycle(1'b1, 16'h0200, 1'b1, 1'b0);
    cycle(1'b0, 16'h0200, 1'b1, 1'b0);
    chk("t5_req_after", {log_req[cyc - 1], log_maddr[cyc - 1]}, {1'b1, 16'h0200});
    wait_idle();

    // Test 6: top-of-memory block, then a back-to-back miss.
    t0 = cyc;
    cycle(1'b1, 16'hFFF8, 1'b1, 1'b0);
    n = 0;
    do begin
      cycle(1'b1, 16'hFFF8, 1'b1, 1'b0);
      n++;
    end while (!log_tag[cyc - 1] && n < 30);
    chk("t6_first_done", log_tag[cyc - 1], 1);
    nw = 0;
    for (int c = t0; c < cyc; c++) if (log_wr[c] && log_faddr[c] >= 16'hFFF0) nw++;
    chk("t6_top_block_writes", nw, 8);
    cycle(1'b1, 16'h0010, 1'b1, 1'b0);
    chk("t6_gap_idle", log_busy[cyc - 1], 0);
    cycle(1'b0, 16'h0010, 1'b1, 1'b0);
    chk("t6_second_req", {log_req[cyc - 1], log_maddr[cyc - 1]}, {1'b1, 16'h0010});
    wait_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(399) == 0) begin
        rst = 1'b0;
        cycle($urandom_range(1), 16'($urandom), 1'b1, 1'b1);
        rst = 1'b1;
      end else begin
        cycle($urandom_range(3) == 0, 16'($urandom), $urandom_range(3) != 0,
              $urandom_range(2) == 0);
      end
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
